// File: rtl/avmm_ccip_host_rd_split.sv
// Splits AVMM burst reads into naturally aligned 1/2/4-line CCI-P c0 read requests, with line-credit flow control.
// c0tx = {vc_sel, rsvd1, cl_len, req_type, rsvd0[5:0], address, mdata, valid}; c0rx = {hdr[27:0], data, rspValid, mmioRdValid, mmioWrValid}.
module avmm_ccip_host_rd_split #(
  parameter int         DATA_WIDTH      = 512,
  parameter int         ADDR_WIDTH      = 48,
  parameter int         BURST_WIDTH     = 4,
  parameter int         MAX_OUTSTANDING = 64,
  parameter bit         RD_SHARED       = 1'b0,
  parameter logic [1:0] VC              = 2'd2,  // eVC_VH0
  localparam int        CL_W            = ADDR_WIDTH - 6,
  localparam int        TX_W            = CL_W + 33,
  localparam int        RX_W            = DATA_WIDTH + 31,
  localparam int        OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  avmm_address,
  input  logic                   avmm_read,
  input  logic [BURST_WIDTH-1:0] avmm_burstcount,
  output logic                   avmm_waitrequest,
  output logic [DATA_WIDTH-1:0]  avmm_readdata,
  output logic                   avmm_readdatavalid,
  input  logic                   c0TxAlmFull,
  input  logic [RX_W-1:0]        c0rx,
  output logic [TX_W-1:0]        c0tx,
  output logic [OUT_W-1:0]       outstanding,
  output logic                   idle
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_ISSUE   = 1'b1;
  localparam int         MAX_BURST  = 2 ** (BURST_WIDTH - 1);
  localparam logic [3:0] REQ_TYPE   = RD_SHARED ? 4'h1 : 4'h0;  // eREQ_RDLINE_S : eREQ_RDLINE_I
  localparam logic [3:0] RSP_RDLINE = 4'h0;
  localparam int         RSP_LSB    = DATA_WIDTH + 19;          // resp_type position inside c0rx

  logic [0:0]             state_q, state_d;
  logic                   rdy_q;
  logic [CL_W-1:0]        addr_q, addr_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [15:0]            mdata_q;
  logic [OUT_W-1:0]       out_q, out_d;
  logic [TX_W-1:0]        tx_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   rvalid_q;

  logic                   accept, issue, rsp_rdline;
  logic [2:0]             len;
  logic [1:0]             cl_len;
  logic [BURST_WIDTH-1:0] burst_lines;
  int                     out_add;
  logic                   unused_bits;

  assign avmm_waitrequest = (state_q == ST_ISSUE) | ~rdy_q;
  assign accept           = (state_q == ST_IDLE) & avmm_read & ~avmm_waitrequest;
  assign rsp_rdline       = c0rx[2] & (c0rx[RSP_LSB+3:RSP_LSB] == RSP_RDLINE);
  assign issue            = (state_q == ST_ISSUE) & ~c0TxAlmFull &
                            (int'(out_q) + int'(len) <= MAX_OUTSTANDING);
  assign unused_bits      = ^{avmm_address[5:0], c0rx[1:0], c0rx[RX_W-1:RSP_LSB+4],
                              c0rx[RSP_LSB-1:DATA_WIDTH+3]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    burst_lines = avmm_burstcount;
    if (avmm_burstcount == '0) begin
      burst_lines = BURST_WIDTH'(1);
    end else if (int'(avmm_burstcount) > MAX_BURST) begin
      burst_lines = BURST_WIDTH'(MAX_BURST);
    end

    len    = 3'd1;
    cl_len = 2'b00;
    if (int'(rem_q) >= 4 && addr_q[1:0] == 2'b00) begin
      len    = 3'd4;
      cl_len = 2'b11;
    end else if (int'(rem_q) >= 2 && !addr_q[0]) begin
      len    = 3'd2;
      cl_len = 2'b01;
    end

    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    if (accept) begin
      state_d = ST_ISSUE;
      addr_d  = avmm_address[ADDR_WIDTH-1:6];
      rem_d   = burst_lines;
    end else if (issue) begin
      addr_d = addr_q + CL_W'(len);
      rem_d  = rem_q - BURST_WIDTH'(len);
      if (rem_q == BURST_WIDTH'(len)) state_d = ST_IDLE;
    end

    // Stray responses (e.g. for requests issued before a reset) never drive the count below zero.
    out_add = int'(out_q) + (issue ? int'(len) : 0);
    out_d   = (rsp_rdline && out_add != 0) ? OUT_W'(out_add - 1) : OUT_W'(out_add);
  end

  // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      mdata_q  <= '0;
      out_q    <= '0;
      tx_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= ~c0TxAlmFull;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      rvalid_q <= rsp_rdline;
      if (issue) begin
        tx_q    <= {VC, 2'b00, cl_len, REQ_TYPE, 6'b000000, addr_q, mdata_q, 1'b1};
        mdata_q <= mdata_q + 16'd1;
      end else begin
        tx_q[0] <= 1'b0;
      end
    end
  end

  // NOTE: read data is a pipeline register qualified by readdatavalid, so it needs no reset.
  always_ff @(posedge clk) begin
    rdata_q <= c0rx[DATA_WIDTH+2:3];
  end

  assign c0tx               = tx_q;
  assign avmm_readdata      = rdata_q;
  assign avmm_readdatavalid = rvalid_q;
  assign outstanding        = out_q;
  assign idle               = (state_q == ST_IDLE) && (out_q == '0);

endmodule

// File: tb/tb_avmm_ccip_host_rd_split.sv
// Randomized and directed bench for avmm_ccip_host_rd_split against a chunk-list / credit reference model.
`timescale 1ns/1ps
module tb_avmm_ccip_host_rd_split;

  localparam int DW      = 512;
  localparam int AW      = 48;
  localparam int BW      = 4;
  localparam int CL_W    = AW - 6;
  localparam int TX_W    = CL_W + 33;
  localparam int RX_W    = DW + 31;
  localparam int MAX_OUT = 64;

  typedef struct {
    int              len;
    logic [CL_W-1:0] addr;
  } chunk_t;

  logic            clk, reset;
  logic [AW-1:0]   avmm_address;
  logic            avmm_read;
  logic [BW-1:0]   avmm_burstcount;
  logic            avmm_waitrequest;
  logic [DW-1:0]   avmm_readdata;
  logic            avmm_readdatavalid;
  logic            c0TxAlmFull;
  logic [RX_W-1:0] c0rx;
  logic [TX_W-1:0] c0tx;
  logic [6:0]      outstanding;
  logic            idle;

  logic [AW-1:0]   addr4;
  logic            read4;
  logic [BW-1:0]   burst4;
  logic            wr4;
  logic [DW-1:0]   rdata4;
  logic            rdv4;
  logic            alm4;
  logic [RX_W-1:0] rx4;
  logic [TX_W-1:0] tx4;
  logic [2:0]      out4;
  logic            idle4;

  chunk_t          exp_q[$];
  chunk_t          dir_q[$];
  int              m_out;
  logic [15:0]     m_mdata;
  bit              rsp_drv, wr_seen, accepted_flag, rsp_en, alm_rand;
  logic [DW-1:0]   rsp_data;
  int              n_cmp, n_err;

  avmm_ccip_host_rd_split dut (
    .clk(clk), .reset(reset),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_burstcount(avmm_burstcount),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .c0TxAlmFull(c0TxAlmFull),
    .c0rx(c0rx), .c0tx(c0tx), .outstanding(outstanding), .idle(idle)
  );

  avmm_ccip_host_rd_split #(.MAX_OUTSTANDING(4)) dut4 (
    .clk(clk), .reset(reset),
    .avmm_address(addr4), .avmm_read(read4), .avmm_burstcount(burst4),
    .avmm_waitrequest(wr4), .avmm_readdata(rdata4), .avmm_readdatavalid(rdv4),
    .c0TxAlmFull(alm4), .c0rx(rx4), .c0tx(tx4), .outstanding(out4), .idle(idle4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc_len(input int len);
    case (len)
      4:       return 2'b11;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [RX_W-1:0] make_rx(input logic [3:0] rtype, input logic [DW-1:0] data);
    return {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, rtype, 16'h0000, data, 1'b1, 1'b0, 1'b0};
  endfunction

  // Expected chunk list: largest of 4/2/1 lines that fits the remaining count and is aligned to its size.
  function automatic void plan(input logic [CL_W-1:0] cl, input int bc);
    int n;
    logic [CL_W-1:0] a;
    chunk_t c;
    n = (bc == 0) ? 1 : ((bc > 8) ? 8 : bc);
    a = cl;
    while (n > 0) begin
      int sz;
      sz = 4;
      while (sz > 1 && !(n >= sz && (int'(a[1:0]) % sz) == 0)) sz = sz / 2;
      c.len  = sz;
      c.addr = a;
      exp_q.push_back(c);
      a = a + CL_W'(sz);
      n = n - sz;
    end
  endfunction

  task automatic add_dir(input int len, input logic [CL_W-1:0] a);
    chunk_t c;
    c.len  = len;
    c.addr = a;
    dir_q.push_back(c);
  endtask

  // One clock: check outputs of the edge just passed against the model, then drive the next inputs.
  task automatic cycle();
    bit     exp_valid;
    chunk_t cur;
    @(negedge clk);
    accepted_flag = 1'b0;
    exp_valid = 1'b0;
    if (exp_q.size() > 0) exp_valid = !c0TxAlmFull && (m_out + exp_q[0].len <= MAX_OUT);
    check("tx_valid", c0tx[0], exp_valid);
    if (exp_valid) begin
      cur = exp_q.pop_front();
      check("tx_cl_len", c0tx[70:69], enc_len(cur.len));
      check("tx_addr", c0tx[58:17], cur.addr);
      check("tx_mdata", c0tx[16:1], m_mdata);
      check("tx_req_type", c0tx[68:65], 4'h0);
      check("tx_vc_rsvd", {c0tx[74:71], c0tx[64:59]}, {2'd2, 2'b00, 6'b000000});
      m_out   = m_out + cur.len;
      m_mdata = m_mdata + 16'd1;
    end
    if (avmm_read && !wr_seen) begin
      accepted_flag = 1'b1;
      if (dir_q.size() > 0) begin
        exp_q = dir_q;
        dir_q.delete();
      end else begin
        plan(avmm_address[AW-1:6], int'(avmm_burstcount));
      end
    end
    if (rsp_drv && m_out > 0) m_out = m_out - 1;
    check("rd_valid", avmm_readdatavalid, rsp_drv);
    if (rsp_drv) check("rd_data", avmm_readdata, rsp_data);
    check("outstanding", outstanding, m_out);
    check("waitrequest", avmm_waitrequest, (exp_q.size() > 0) || c0TxAlmFull);
    check("idle", idle, (exp_q.size() == 0) && (m_out == 0));
    wr_seen = avmm_waitrequest;

    rsp_drv = 1'b0;
    c0rx    = '0;
    if (rsp_en && $urandom_range(0, 3) != 0) begin
      if ($urandom_range(0, 4) == 0) begin
        c0rx = make_rx(4'h1, rand_data());
      end else if (m_out > 0) begin
        rsp_data = rand_data();
        c0rx     = make_rx(4'h0, rsp_data);
        rsp_drv  = 1'b1;
      end
    end
    if (alm_rand) c0TxAlmFull = ($urandom_range(0, 3) == 0);
  endtask

  task automatic issue_cmd(input logic [CL_W-1:0] cl, input int bc);
    avmm_address    = {cl, 6'($urandom)};
    avmm_burstcount = BW'(bc);
    avmm_read       = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (accepted_flag) break;
    end
    if (!accepted_flag) check("accept_timeout", 1'b0, 1'b1);
    avmm_read = 1'b0;
  endtask

  task automatic drain(input bit need_credits);
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && (!need_credits || m_out == 0)) break;
      cycle();
    end
    if (exp_q.size() != 0 || (need_credits && m_out != 0)) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_waitrequest"}, avmm_waitrequest, 1'b1);
    check({pfx, "_tx_valid"}, c0tx[0], 1'b0);
    check({pfx, "_rd_valid"}, avmm_readdatavalid, 1'b0);
    check({pfx, "_outstanding"}, outstanding, 0);
    check({pfx, "_idle"}, idle, 1'b1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_waitrequest", avmm_waitrequest, 1'b1);
    exp_q.delete();
    dir_q.delete();
    m_out       = 0;
    m_mdata     = 16'h0000;
    rsp_drv     = 1'b0;
    c0rx        = '0;
    c0TxAlmFull = 1'b0;
    wr_seen     = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    avmm_address = '0; avmm_read = 1'b0; avmm_burstcount = '0;
    c0TxAlmFull = 1'b0; c0rx = '0;
    addr4 = '0; read4 = 1'b0; burst4 = '0; alm4 = 1'b0; rx4 = '0;
    rsp_en = 1'b0; alm_rand = 1'b0; rsp_data = '0;
    #1;
    reset_checks("reset");
    release_reset();

    // Aligned burst of 8 -> two 4-line chunks, 8 lines in flight.
    add_dir(4, 42'h1000); add_dir(4, 42'h1004);
    issue_cmd(42'h1000, 8);
    drain(1'b0);
    check("burst8_outstanding", outstanding, 8);

    add_dir(1, 42'h1001); add_dir(2, 42'h1002);
    issue_cmd(42'h1001, 3);
    drain(1'b0);

    add_dir(2, 42'h1002); add_dir(2, 42'h1004); add_dir(1, 42'h1006);
    issue_cmd(42'h1002, 5);
    drain(1'b0);

    // Almost-full held for 5 cycles between the two chunks of a burst.
    add_dir(4, 42'h2000); add_dir(4, 42'h2004);
    issue_cmd(42'h2000, 8);
    cycle();
    c0TxAlmFull = 1'b1;
    repeat (5) begin
      cycle();
      check("almfull_no_valid", c0tx[0], 1'b0);
      check("almfull_waitrequest", avmm_waitrequest, 1'b1);
    end
    c0TxAlmFull = 1'b0;
    drain(1'b0);

    // Burstcount 0 means one line; above MAX_BURST clamps to 8.
    add_dir(1, 42'h3000);
    issue_cmd(42'h3000, 0);
    add_dir(4, 42'h3010); add_dir(4, 42'h3014);
    issue_cmd(42'h3010, 15);
    drain(1'b0);

    rsp_en = 1'b1;
    drain(1'b1);

    alm_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      issue_cmd(CL_W'($urandom), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) cycle();
    end
    alm_rand = 1'b0;
    c0TxAlmFull = 1'b0;
    drain(1'b1);

    // Reset in the middle of a burst, while a chunk is on c0tx.
    rsp_en = 1'b0;
    add_dir(2, 42'h1002); add_dir(2, 42'h1004); add_dir(1, 42'h1006);
    issue_cmd(42'h1002, 5);
    cycle();
    #2;
    reset = 1'b1;
    #1;
    reset_checks("midburst_reset");
    release_reset();
    add_dir(1, 42'h20);
    issue_cmd(42'h20, 1);
    drain(1'b0);

    // Credit limit of 4: second chunk waits for four RDLINE responses.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!wr4) break;
    end
    check("c4_ready", wr4, 1'b0);
    addr4 = '0; burst4 = 4'd8; read4 = 1'b1;
    @(negedge clk);
    read4 = 1'b0;
    check("c4_no_early_valid", tx4[0], 1'b0);
    check("c4_busy", wr4, 1'b1);
    @(negedge clk);
    check("c4_chunk0_valid", tx4[0], 1'b1);
    check("c4_chunk0_len", tx4[70:69], 2'b11);
    check("c4_chunk0_addr", tx4[58:17], 42'h0);
    check("c4_chunk0_mdata", tx4[16:1], 16'h0000);
    check("c4_out_full", out4, 4);
    repeat (4) begin
      @(negedge clk);
      check("c4_held_valid", tx4[0], 1'b0);
      check("c4_held_out", out4, 4);
    end
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] d;
      d   = rand_data();
      rx4 = make_rx(4'h0, d);
      @(negedge clk);
      check("c4_rsp_valid", rdv4, 1'b1);
      check("c4_rsp_data", rdata4, d);
      check("c4_rsp_out", out4, 3 - k);
      check("c4_rsp_no_issue", tx4[0], 1'b0);
    end
    rx4 = '0;
    @(negedge clk);
    check("c4_rsp_done_valid", rdv4, 1'b0);
    check("c4_chunk1_valid", tx4[0], 1'b1);
    check("c4_chunk1_len", tx4[70:69], 2'b11);
    check("c4_chunk1_addr", tx4[58:17], 42'h4);
    check("c4_chunk1_mdata", tx4[16:1], 16'h0001);
    check("c4_chunk1_out", out4, 4);
    @(negedge clk);
    check("c4_end_valid", tx4[0], 1'b0);
    check("c4_end_waitrequest", wr4, 1'b0);
    check("c4_end_idle", idle4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
